game_sequencer: RTL and testbench

Cycle-level controller that sequences the snake game datapath. It divides the system clock into game ticks at one of two rates and debounces and latches the two turn buttons into a single pending turn. It issues one step request per tick to the field/snake datapath and waits for the step's completion. It then requests a display refresh and a sound, and owns the hold/play/step/game-over state that the datapath previously derived on its own.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/game_sequencer_debounce.sv | 62 ++++++
 rtl/game_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer.
// No ports. Provides:
//   GameState - sequencer FSM states (HOLD/PLAY/STEP/OVER), also shown on the debug LEDs
//   TurnCode  - turn requested with a step (none/left/right)
//   SoundCode - tune selection sent to the piezo block (game-over/step/apple)
package snake_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    PLAY = 2'b01,
    STEP = 2'b10,
    OVER = 2'b11
  } GameState;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'b00,
    TURN_LEFT  = 2'b01,
    TURN_RIGHT = 2'b10
  } TurnCode;

  typedef enum logic [1:0] {
    SND_OVER  = 2'b00,
    SND_STEP  = 2'b01,
    SND_APPLE = 2'b10
  } SoundCode;

endpackage

// File: rtl/game_sequencer_debounce.sv
// Button debouncer for one active-low push button.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   btnN   - raw active-low button, asynchronous to clk
//   press  - one-cycle pulse when a press (released -> pressed) has been accepted
// The raw input is synchronised with two flops. A change is accepted only after
// the synchronised level has differed from the accepted level for 2^DEB_W cycles
// in a row; any bounce back to the accepted level restarts the count.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnN,
  output logic press
);

  logic             syncMeta;
  logic             synced;
  logic             accepted;
  logic [DEB_W-1:0] stableCnt;
  logic             differ;
  logic             cntFull;

  assign differ  = (synced != accepted);
  assign cntFull = &stableCnt;

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= 1'b1;
      synced   <= 1'b1;
    end else begin
      syncMeta <= btnN;
      synced   <= syncMeta;
    end
  end

  // Stability counter and accepted level; press is registered, adding one cycle
  // between acceptance and the pending-turn update in the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stableCnt <= '0;
      accepted  <= 1'b1;
      press     <= 1'b0;
    end else begin
      press <= differ && cntFull && !synced;
      if (!differ) begin
        stableCnt <= '0;
      end else if (cntFull) begin
        stableCnt <= '0;
        accepted  <= synced;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Snake game sequencer: tick generation, turn-button handling and the
// hold/play/step/game-over control of the field/snake datapath.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   btn_l_n, btn_r_n    - raw active-low turn buttons (asynchronous)
//   run_sw              - 0 holds the game at its initial position, 1 runs it
//   speed_sw            - 1 doubles the tick rate
//   step_done           - datapath finished the requested step (pulse)
//   collision, apple    - step result, valid with step_done
//   step_req, step_turn - step request pulse and its turn code
//   load_init           - level: datapath loads the initial snake and apple
//   refresh             - pulse: redraw the displays
//   snd_req, snd_code   - sound request pulse and tune selection
//   step_miss           - pulse: a tick was dropped while a step was outstanding
//   state               - current FSM state for debug/LEDs
module game_sequencer
  import snake_pkg::*;
#(
  parameter int DIV_W = 25,
  parameter int DEB_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_l_n,
  input  logic       btn_r_n,
  input  logic       run_sw,
  input  logic       speed_sw,
  input  logic       step_done,
  input  logic       collision,
  input  logic       apple,
  output logic       step_req,
  output logic [1:0] step_turn,
  output logic       load_init,
  output logic       refresh,
  output logic       snd_req,
  output logic [1:0] snd_code,
  output logic       step_miss,
  output logic [1:0] state
);

  logic             leftPress;
  logic             rightPress;
  logic             runMeta;
  logic             runSync;
  logic [DIV_W-1:0] acc;
  logic [DIV_W:0]   accSum;
  logic             tick;
  logic             issueStep;
  TurnCode          pressTurn;
  TurnCode          pendingTurn;
  GameState         stateQ;

  assign state = stateQ;

  btn_debounce #(.DEB_W(DEB_W)) leftDebounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btnN  (btn_l_n),
    .press (leftPress)
  );

  btn_debounce #(.DEB_W(DEB_W)) rightDebounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btnN  (btn_r_n),
    .press (rightPress)
  );

  // run_sw comes from a mechanical switch, so it is synchronised before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runMeta <= 1'b0;
      runSync <= 1'b0;
    end else begin
      runMeta <= run_sw;
      runSync <= runMeta;
    end
  end

  // The tick is the carry out of the accumulator; adding 2 halves the period.
  assign accSum = {1'b0, acc} + {{(DIV_W-1){1'b0}}, speed_sw, ~speed_sw};
  assign tick   = accSum[DIV_W];

  // acc is held at zero in HOLD so the first step comes a full period after the game starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (stateQ == HOLD) begin
      acc <= '0;
    end else begin
      acc <= accSum[DIV_W-1:0];
    end
  end

  // Simultaneous left and right presses cancel each other.
  always_comb begin
    pressTurn = TURN_NONE;
    if (leftPress && !rightPress) begin
      pressTurn = TURN_LEFT;
    end else if (rightPress && !leftPress) begin
      pressTurn = TURN_RIGHT;
    end
  end

  assign issueStep = (stateQ == PLAY) && runSync && tick;

  // Pending turn: first press wins. When a step consumes the pending turn, a press
  // arriving in that same cycle is kept for the following step instead of being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendingTurn <= TURN_NONE;
    end else if (stateQ == HOLD) begin
      pendingTurn <= TURN_NONE;
    end else if (issueStep) begin
      pendingTurn <= pressTurn;
    end else if (pendingTurn == TURN_NONE) begin
      pendingTurn <= pressTurn;
    end
  end

  // Sequencer FSM with registered outputs. Dropping run_sw always wins and abandons
  // any outstanding step; step_done is only honoured in STEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= HOLD;
      step_req  <= 1'b0;
      step_turn <= TURN_NONE;
      load_init <= 1'b0;
      refresh   <= 1'b0;
      snd_req   <= 1'b0;
      snd_code  <= SND_OVER;
      step_miss <= 1'b0;
    end else begin
      step_req  <= 1'b0;
      step_turn <= TURN_NONE;
      refresh   <= 1'b0;
      snd_req   <= 1'b0;
      snd_code  <= SND_OVER;
      step_miss <= 1'b0;
      if (!runSync) begin
        stateQ    <= HOLD;
        load_init <= 1'b1;
      end else begin
        case (stateQ)
          HOLD: begin
            stateQ    <= PLAY;
            load_init <= 1'b0;
            refresh   <= 1'b1;
          end
          PLAY: begin
            if (tick) begin
              stateQ    <= STEP;
              step_req  <= 1'b1;
              step_turn <= pendingTurn;
            end
          end
          STEP: begin
            if (step_done) begin
              refresh <= 1'b1;
              snd_req <= 1'b1;
              if (collision) begin
                stateQ   <= OVER;
                snd_code <= SND_OVER;
              end else begin
                stateQ   <= PLAY;
                snd_code <= apple ? SND_APPLE : SND_STEP;
              end
            end
            if (tick) begin
              step_miss <= 1'b1;
            end
          end
          OVER: begin
            if (tick) begin
              refresh  <= 1'b1;
              snd_req  <= 1'b1;
              snd_code <= SND_OVER;
            end
          end
          default: begin
            stateQ <= HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with DIV_W=4, DEB_W=2.
// Expected pulses are queued per output with their expected cycle; a monitor pops
// and compares whenever the DUT raises step_req, refresh, snd_req or step_miss.
// Cycle numbers are relative to the negedge at which rst_n is released (baseCyc):
// the sequencer sees run_sw at +2, enters PLAY at +3 (refresh), and the first
// tick at the slow rate gives step_req at +19, then every 16 cycles.
module tb_game_sequencer;

  localparam int DIV_W = 4;
  localparam int DEB_W = 2;

  logic       clk;
  logic       rst_n;
  logic       btn_l_n;
  logic       btn_r_n;
  logic       run_sw;
  logic       speed_sw;
  logic       step_done;
  logic       collision;
  logic       apple;
  logic       step_req;
  logic [1:0] step_turn;
  logic       load_init;
  logic       refresh;
  logic       snd_req;
  logic [1:0] snd_code;
  logic       step_miss;
  logic [1:0] state;

  typedef struct {
    int value;
    int cyc;
  } Expect;

  Expect stepQ[$];
  Expect refreshQ[$];
  Expect sndQ[$];
  Expect missQ[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   baseCyc = 0;
  int   resetGen = 0;
  int   respDelay = 3;
  logic cfgCollision = 1'b0;
  logic cfgApple = 1'b0;

  game_sequencer #(.DIV_W(DIV_W), .DEB_W(DEB_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_l_n   (btn_l_n),
    .btn_r_n   (btn_r_n),
    .run_sw    (run_sw),
    .speed_sw  (speed_sw),
    .step_done (step_done),
    .collision (collision),
    .apple     (apple),
    .step_req  (step_req),
    .step_turn (step_turn),
    .load_init (load_init),
    .refresh   (refresh),
    .snd_req   (snd_req),
    .snd_code  (snd_code),
    .step_miss (step_miss),
    .state     (state)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive the buttons (1 = pressed) at a cycle relative to the last reset release.
  task automatic applyStimulus(input int at, input logic pressL, input logic pressR);
    waitUntil(baseCyc + at);
    btn_l_n = ~pressL;
    btn_r_n = ~pressR;
  endtask

  task automatic expectStep(input int turn, input int at);
    Expect e;
    e.value = turn;
    e.cyc   = at;
    stepQ.push_back(e);
  endtask

  task automatic expectRefresh(input int at);
    Expect e;
    e.value = 1;
    e.cyc   = at;
    refreshQ.push_back(e);
  endtask

  task automatic expectSnd(input int code, input int at);
    Expect e;
    e.value = code;
    e.cyc   = at;
    sndQ.push_back(e);
  endtask

  task automatic expectMiss(input int at);
    Expect e;
    e.value = 1;
    e.cyc   = at;
    missQ.push_back(e);
  endtask

  task automatic checkQueuesEmpty();
    checkOutput("leftover step_req", stepQ.size(), 0);
    checkOutput("leftover refresh", refreshQ.size(), 0);
    checkOutput("leftover snd_req", sndQ.size(), 0);
    checkOutput("leftover step_miss", missQ.size(), 0);
    stepQ.delete();
    refreshQ.delete();
    sndQ.delete();
    missQ.delete();
  endtask

  // Called at a negedge; releases reset two cycles later with the given switches.
  task automatic doReset(input logic run, input logic speed);
    #2 rst_n = 1'b0;
    resetGen++;
    checkQueuesEmpty();
    repeat (2) @(negedge clk);
    btn_l_n      = 1'b1;
    btn_r_n      = 1'b1;
    run_sw       = run;
    speed_sw     = speed;
    cfgCollision = 1'b0;
    cfgApple     = 1'b0;
    respDelay    = 3;
    rst_n        = 1'b1;
    baseCyc      = cyc;
  endtask

  // Datapath model: answers each step_req after respDelay cycles and queues the
  // refresh and sound the sequencer must produce one cycle later.
  initial begin : responder
    int myGen;
    int d;
    step_done = 1'b0;
    collision = 1'b0;
    apple     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && step_req) begin
        myGen = resetGen;
        d     = respDelay;
        repeat (d) @(negedge clk);
        step_done = 1'b1;
        collision = cfgCollision;
        apple     = cfgApple;
        if (myGen == resetGen) begin
          expectRefresh(cyc + 1);
          expectSnd(cfgCollision ? 0 : (cfgApple ? 2 : 1), cyc + 1);
        end
        @(negedge clk);
        step_done = 1'b0;
        collision = 1'b0;
        apple     = 1'b0;
      end
    end
  end

  // Monitor: every output pulse must match the head of its queue, value and cycle.
  always @(negedge clk) begin
    Expect e;
    if (rst_n) begin
      if (step_req) begin
        if (stepQ.size() == 0) begin
          checkOutput("spurious step_req", int'(step_req), 0);
        end else begin
          e = stepQ.pop_front();
          checkOutput("step_turn", int'(step_turn), e.value);
          checkOutput("step_req cycle", cyc, e.cyc);
        end
      end
      if (refresh) begin
        if (refreshQ.size() == 0) begin
          checkOutput("spurious refresh", int'(refresh), 0);
        end else begin
          e = refreshQ.pop_front();
          checkOutput("refresh cycle", cyc, e.cyc);
        end
      end
      if (snd_req) begin
        if (sndQ.size() == 0) begin
          checkOutput("spurious snd_req", int'(snd_req), 0);
        end else begin
          e = sndQ.pop_front();
          checkOutput("snd_code", int'(snd_code), e.value);
          checkOutput("snd_req cycle", cyc, e.cyc);
        end
      end
      if (step_miss) begin
        if (missQ.size() == 0) begin
          checkOutput("spurious step_miss", int'(step_miss), 0);
        end else begin
          e = missQ.pop_front();
          checkOutput("step_miss cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    btn_l_n  = 1'b1;
    btn_r_n  = 1'b1;
    run_sw   = 1'b0;
    speed_sw = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("reset state", int'(state), 0);
    checkOutput("reset load_init", int'(load_init), 0);
    checkOutput("reset step_req", int'(step_req), 0);
    checkOutput("reset refresh", int'(refresh), 0);
    checkOutput("reset snd_req", int'(snd_req), 0);
    checkOutput("reset step_miss", int'(step_miss), 0);
    checkOutput("reset step_turn", int'(step_turn), 0);
    checkOutput("reset snd_code", int'(snd_code), 0);

    // Normal play at slow rate: steps every 16 cycles, step clicks
    doReset(1'b1, 1'b0);
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    expectStep(0, baseCyc + 35);
    expectStep(0, baseCyc + 51);
    waitUntil(baseCyc + 1);
    checkOutput("hold load_init", int'(load_init), 1);
    checkOutput("hold state", int'(state), 0);
    waitUntil(baseCyc + 3);
    checkOutput("play load_init", int'(load_init), 0);
    checkOutput("play state", int'(state), 1);
    waitUntil(baseCyc + 20);
    checkOutput("step state", int'(state), 2);
    waitUntil(baseCyc + 60);
    checkOutput("back to play state", int'(state), 1);

    // Double rate with apples: steps every 8 cycles, apple sound
    doReset(1'b1, 1'b1);
    cfgApple = 1'b1;
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 11);
    expectStep(0, baseCyc + 19);
    expectStep(0, baseCyc + 27);
    waitUntil(baseCyc + 34);

    // Left held 10 cycles, a 2-cycle glitch, then a right press
    doReset(1'b1, 1'b0);
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    expectStep(1, baseCyc + 35);
    expectStep(0, baseCyc + 51);
    expectStep(2, baseCyc + 67);
    applyStimulus(20, 1'b1, 1'b0);
    applyStimulus(30, 1'b0, 1'b0);
    applyStimulus(40, 1'b1, 1'b0);
    applyStimulus(42, 1'b0, 1'b0);
    applyStimulus(52, 1'b0, 1'b1);
    applyStimulus(62, 1'b0, 1'b0);
    waitUntil(baseCyc + 72);

    // Simultaneous presses cancel; later, first of two presses wins
    doReset(1'b1, 1'b0);
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    expectStep(0, baseCyc + 35);
    expectStep(1, baseCyc + 51);
    applyStimulus(20, 1'b1, 1'b1);
    applyStimulus(28, 1'b0, 1'b0);
    applyStimulus(36, 1'b1, 1'b0);
    applyStimulus(38, 1'b1, 1'b1);
    applyStimulus(44, 1'b0, 1'b1);
    applyStimulus(46, 1'b0, 1'b0);
    waitUntil(baseCyc + 56);

    // Slow datapath: tick during STEP is dropped with step_miss
    doReset(1'b1, 1'b0);
    respDelay = 20;
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    expectMiss(baseCyc + 35);
    expectStep(0, baseCyc + 51);
    waitUntil(baseCyc + 21);
    respDelay = 3;
    waitUntil(baseCyc + 36);
    checkOutput("still step after miss", int'(state), 2);
    waitUntil(baseCyc + 41);
    checkOutput("play after late done", int'(state), 1);
    waitUntil(baseCyc + 58);

    // Collision with apple: game over, march on each tick, then back to HOLD
    doReset(1'b1, 1'b0);
    cfgCollision = 1'b1;
    cfgApple     = 1'b1;
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    waitUntil(baseCyc + 25);
    checkOutput("over state", int'(state), 3);
    cfgCollision = 1'b0;
    cfgApple     = 1'b0;
    expectRefresh(baseCyc + 35);
    expectSnd(0, baseCyc + 35);
    expectRefresh(baseCyc + 51);
    expectSnd(0, baseCyc + 51);
    waitUntil(baseCyc + 55);
    run_sw = 1'b0;
    waitUntil(baseCyc + 57);
    checkOutput("over before sync", int'(state), 3);
    waitUntil(baseCyc + 58);
    checkOutput("hold after run off", int'(state), 0);
    checkOutput("load_init after run off", int'(load_init), 1);
    waitUntil(baseCyc + 62);

    // Asynchronous reset in the middle of a step; step_done during reset is lost
    doReset(1'b1, 1'b0);
    respDelay = 2;
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    waitUntil(baseCyc + 20);
    checkOutput("step before reset", int'(state), 2);
    #2 rst_n = 1'b0;
    resetGen++;
    #1;
    checkOutput("async reset state", int'(state), 0);
    checkOutput("async reset load_init", int'(load_init), 0);
    checkOutput("async reset step_req", int'(step_req), 0);
    checkOutput("async reset refresh", int'(refresh), 0);
    checkOutput("async reset snd_req", int'(snd_req), 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    baseCyc   = cyc;
    respDelay = 3;
    expectRefresh(baseCyc + 3);
    expectStep(0, baseCyc + 19);
    waitUntil(baseCyc + 25);
    checkOutput("play after reset recovery", int'(state), 1);
    checkQueuesEmpty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
